// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-path types: fetch-buffer entry, fetch FSM states, group sizing.
package fetch_ctrl_pkg;

  localparam int unsigned INST_FETCH_NUM = 4;
  localparam int unsigned FETCH_ALIGN    = $clog2(INST_FETCH_NUM * 4);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } ib_entry_t;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc, input int unsigned bits);
    return (pc >> bits) << bits;
  endfunction

endpackage

// File: rtl/fetch_pack.sv
// Combinational slot packer: splits an I-cache line into fetch-buffer entries.
module fetch_pack
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned FETCH_NUM = INST_FETCH_NUM
) (
  input  logic [32*FETCH_NUM-1:0]        data,
  input  logic [31:0]                    base_pc,
  input  logic [31:0]                    offset,
  output ib_entry_t [FETCH_NUM-1:0]      entries
);

  // Slots below the entry offset belong to bytes before the fetch target.
  always_comb begin
    entries = '0;
    for (int unsigned i = 0; i < FETCH_NUM; i++) begin
      entries[i].inst  = data[32*i +: 32];
      entries[i].pc    = base_pc + 32'(4 * i);
      entries[i].valid = (i >= offset);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues group-aligned I-cache requests, packs responses into
// the fetch buffer, and handles backend redirects with stale-response dropping.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned FETCH_NUM = INST_FETCH_NUM,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       ic_req_valid,
  output logic [31:0]                ic_req_addr,
  input  logic                       ic_req_ready,
  input  logic                       ic_resp_valid,
  input  logic [32*FETCH_NUM-1:0]    ic_resp_data,
  output ib_entry_t [FETCH_NUM-1:0]  fb_insts,
  output logic                       fb_valid,
  input  logic                       fb_full,
  output logic                       fb_flush,
  output logic [31:0]                fetch_pc
);

  localparam int unsigned ALIGN       = $clog2(FETCH_NUM * 4);
  localparam logic [31:0] GROUP_BYTES = 32'(FETCH_NUM * 4);

  fetch_state_t              state;
  logic                      drop;
  ib_entry_t [FETCH_NUM-1:0] packed_grp;
  ib_entry_t [FETCH_NUM-1:0] hold_grp;
  logic [31:0]               base_pc;
  logic [31:0]               next_pc;
  logic [31:0]               slot_off;
  logic                      req_fire;
  logic                      resp_live;
  logic                      push_now;
  logic                      push_held;
  logic                      own_out;

  assign base_pc     = align_pc(fetch_pc, ALIGN);
  assign next_pc     = base_pc + GROUP_BYTES;
  assign slot_off    = (fetch_pc - base_pc) >> 2;
  assign ic_req_addr = base_pc;

  fetch_pack #(.FETCH_NUM(FETCH_NUM)) u_pack (
    .data    (ic_resp_data),
    .base_pc (base_pc),
    .offset  (slot_off),
    .entries (packed_grp)
  );

  assign req_fire  = (state == REQ) && ic_req_valid && ic_req_ready;
  assign resp_live = (state == WAIT) && ic_resp_valid && !drop;
  assign push_now  = resp_live && !fb_full && !redirect_valid;
  assign push_held = (state == HOLD) && !fb_full && !redirect_valid;
  assign fb_valid  = push_now || push_held;
  assign fb_flush  = redirect_valid;

  // A request of our own is still in flight after this cycle unless its
  // response is the one arriving right now.
  assign own_out = req_fire || ((state == WAIT) && !(ic_resp_valid && !drop));

  always_comb begin
    fb_insts = '0;
    if (push_held)
      fb_insts = hold_grp;
    else if (push_now)
      fb_insts = packed_grp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= REQ;
      fetch_pc     <= RESET_PC;
      ic_req_valid <= 1'b0;
      drop         <= 1'b0;
      hold_grp     <= '0;
    end else if (redirect_valid) begin
      state        <= REQ;
      fetch_pc     <= redirect_pc;
      ic_req_valid <= 1'b1;
      drop         <= (drop && !ic_resp_valid) || own_out;
      hold_grp     <= '0;
    end else begin
      if (drop && ic_resp_valid)
        drop <= 1'b0;
      unique case (state)
        REQ: begin
          ic_req_valid <= 1'b1;
          if (req_fire) begin
            state        <= WAIT;
            ic_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (resp_live) begin
            if (!fb_full) begin
              fetch_pc     <= next_pc;
              state        <= REQ;
              ic_req_valid <= 1'b1;
            end else begin
              hold_grp <= packed_grp;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!fb_full) begin
            fetch_pc     <= next_pc;
            state        <= REQ;
            ic_req_valid <= 1'b1;
          end
        end
        default: begin
          state        <= REQ;
          ic_req_valid <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a scoreboard of expected fetch groups.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int unsigned N = INST_FETCH_NUM;
  typedef ib_entry_t [N-1:0] group_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             ic_req_valid;
  logic [31:0]      ic_req_addr;
  logic             ic_req_ready;
  logic             ic_resp_valid;
  logic [32*N-1:0]  ic_resp_data;
  group_t           fb_insts;
  logic             fb_valid;
  logic             fb_full;
  logic             fb_flush;
  logic [31:0]      fetch_pc;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  group_t      exp_q[$];

  fetch_ctrl #(.FETCH_NUM(N), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_req_ready   (ic_req_ready),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .fb_insts       (fb_insts),
    .fb_valid       (fb_valid),
    .fb_full        (fb_full),
    .fb_flush       (fb_flush),
    .fetch_pc       (fetch_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] inst_word(input logic [31:0] base, input int unsigned i);
    return {base[15:0], 16'hA500} + 32'(i);
  endfunction

  function automatic logic [32*N-1:0] resp_word(input logic [31:0] base);
    logic [32*N-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < N; i++) d[32*i +: 32] = inst_word(base, i);
    return d;
  endfunction

  function automatic group_t model_group(input logic [31:0] pc);
    group_t      g;
    logic [31:0] base;
    base = {pc[31:4], 4'h0};
    for (int unsigned i = 0; i < N; i++) begin
      g[i].inst  = inst_word(base, i);
      g[i].pc    = base + 32'(4 * i);
      g[i].valid = (i >= 32'(pc[3:2]));
    end
    return g;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_grp(input string tag, input group_t obs, input group_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs, then check push behaviour against the scoreboard.
  task automatic settle(input bit exp_push, input string tag);
    group_t g;
    #2;
    check32({tag, ":fb_valid"}, 32'(fb_valid), 32'(exp_push));
    check32({tag, ":push_while_full"}, 32'(fb_valid && fb_full), 32'h0);
    if (fb_valid) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL %s:unexpected_push: observed %h expected none", tag, fb_insts);
      end
      if (exp_q.size() > 0) begin
        g = exp_q.pop_front();
        check_grp({tag, ":fb_insts"}, fb_insts, g);
      end
    end
  endtask

  task automatic req_phase(input logic [31:0] addr, input string tag);
    settle(1'b0, tag);
    check32({tag, ":req_valid"}, 32'(ic_req_valid), 32'h1);
    check32({tag, ":req_addr"}, ic_req_addr, addr);
    next();
  endtask

  task automatic resp_phase(input logic [31:0] base, input logic [31:0] pc, input bit full,
                            input bit accept, input string tag);
    ic_resp_valid = 1'b1;
    ic_resp_data  = resp_word(base);
    fb_full       = full;
    if (accept) exp_q.push_back(model_group(pc));
    settle(accept && !full, tag);
    next();
    ic_resp_valid = 1'b0;
    ic_resp_data  = '0;
  endtask

  task automatic do_redirect(input logic [31:0] pc, input string tag);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    settle(1'b0, tag);
    check32({tag, ":flush"}, 32'(fb_flush), 32'h1);
    next();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ic_req_ready   = 1'b0;
    ic_resp_valid  = 1'b0;
    ic_resp_data   = '0;
    fb_full        = 1'b0;
    next();
    next();
    settle(1'b0, "rst");
    check32("rst:req_valid", 32'(ic_req_valid), 32'h0);
    check32("rst:flush", 32'(fb_flush), 32'h0);
    check32("rst:fetch_pc", fetch_pc, 32'h0);
    check_grp("rst:fb_insts", fb_insts, '0);

    reset        = 1'b0;
    ic_req_ready = 1'b1;
    next();

    // Straight-line fetch, 1-cycle cache.
    req_phase(32'h0, "g0");   resp_phase(32'h0,  32'h0,  1'b0, 1'b1, "g0");
    req_phase(32'h10, "g1");  resp_phase(32'h10, 32'h10, 1'b0, 1'b1, "g1");
    req_phase(32'h20, "g2");  resp_phase(32'h20, 32'h20, 1'b0, 1'b1, "g2");

    // Redirect in REQ without handshake: no drop, partial first group.
    ic_req_ready = 1'b0;
    do_redirect(32'h108, "redir108");
    ic_req_ready = 1'b1;
    settle(1'b0, "redir108_after");
    check32("redir108:flush_pulse", 32'(fb_flush), 32'h0);
    check32("redir108:fetch_pc", fetch_pc, 32'h108);
    req_phase(32'h100, "g100");
    resp_phase(32'h100, 32'h108, 1'b0, 1'b1, "g100");

    // Buffer full on response: hold, then release.
    req_phase(32'h110, "g110");
    resp_phase(32'h110, 32'h110, 1'b1, 1'b1, "hold_latch");
    for (int i = 0; i < 5; i++) begin
      settle(1'b0, "hold_wait");
      check32("hold_wait:req_valid", 32'(ic_req_valid), 32'h0);
      next();
    end
    fb_full = 1'b0;
    settle(1'b1, "hold_release");
    next();

    // Redirect in WAIT; stale response two cycles later is dropped.
    req_phase(32'h120, "g120");
    do_redirect(32'h200, "redir200");
    req_phase(32'h200, "g200");
    resp_phase(32'h120, 32'h120, 1'b0, 1'b0, "stale");
    resp_phase(32'h200, 32'h200, 1'b0, 1'b1, "post_stale");

    // Redirect coincident with a response: response discarded, no drop.
    req_phase(32'h210, "g210");
    ic_resp_valid = 1'b1;
    ic_resp_data  = resp_word(32'h210);
    do_redirect(32'h300, "coinc");
    ic_resp_valid = 1'b0;
    ic_resp_data  = '0;
    req_phase(32'h300, "g300");
    resp_phase(32'h300, 32'h300, 1'b0, 1'b1, "after_coinc");

    // Address wrap at the top of the space.
    ic_req_ready = 1'b0;
    do_redirect(32'hFFFF_FFF0, "redir_top");
    ic_req_ready = 1'b1;
    req_phase(32'hFFFF_FFF0, "gtop");
    resp_phase(32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b0, 1'b1, "gtop");
    req_phase(32'h0, "wrap");
    resp_phase(32'h0, 32'h0, 1'b0, 1'b1, "wrap");

    // Reset while holding a group.
    req_phase(32'h10, "pre_rst");
    resp_phase(32'h10, 32'h10, 1'b1, 1'b0, "pre_rst_hold");
    settle(1'b0, "in_hold");
    check32("in_hold:fetch_pc", fetch_pc, 32'h10);
    reset = 1'b1;
    #1;
    check32("mid_rst:req_valid", 32'(ic_req_valid), 32'h0);
    check32("mid_rst:fetch_pc", fetch_pc, 32'h0);
    check32("mid_rst:flush", 32'(fb_flush), 32'h0);
    fb_full = 1'b0;
    #1;
    check32("mid_rst:fb_valid", 32'(fb_valid), 32'h0);
    check_grp("mid_rst:fb_insts", fb_insts, '0);
    next();
    next();
    reset = 1'b0;

    // Stray response right after reset is ignored; fetch resumes at RESET_PC.
    ic_resp_valid = 1'b1;
    ic_resp_data  = resp_word(32'h10);
    settle(1'b0, "post_rst_stray");
    next();
    ic_resp_valid = 1'b0;
    ic_resp_data  = '0;
    req_phase(32'h0, "post_rst");
    resp_phase(32'h0, 32'h0, 1'b0, 1'b1, "post_rst");
    settle(1'b0, "tail");

    check32("scoreboard_empty", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
